// File: rtl/entropy_pool_ctrl.sv
// Entropy source sequencer: gates the online health test, discards warm-up bits,
// packs raw bits into words and buffers them in a small FIFO for the conditioner.
module entropy_pool_ctrl #(
    parameter int WORD_W      = 64,
    parameter int POOL_DEPTH  = 4,
    parameter int CAL_TIMEOUT = 4096,
    parameter int WARMUP_BITS = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              adc_in,
    input  logic                              oht_valid,
    input  logic                              oht_perm_fail,
    output logic                              oht_rst,
    output logic                              oht_full,
    output logic [WORD_W-1:0]                 word_out,
    output logic                              word_valid,
    input  logic                              word_ready,
    output logic [$clog2(POOL_DEPTH+1)-1:0]   pool_level,
    output logic [2:0]                        state,
    output logic                              fault
);

    localparam int LVL_W   = $clog2(POOL_DEPTH + 1);
    localparam int PTR_W   = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1;
    localparam int TO_W    = (CAL_TIMEOUT > 1) ? $clog2(CAL_TIMEOUT) : 1;
    localparam int BIT_MAX = (WARMUP_BITS > WORD_W) ? WARMUP_BITS : WORD_W;
    localparam int BC_W    = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(CAL_TIMEOUT - 1);
    localparam logic [BC_W-1:0]  WARM_LAST = BC_W'(WARMUP_BITS - 1);
    localparam logic [BC_W-1:0]  WORD_LAST = BC_W'(WORD_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(POOL_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(POOL_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALIB   = 3'd1,
        S_WARMUP  = 3'd2,
        S_COLLECT = 3'd3,
        S_STALL   = 3'd4,
        S_FAULT   = 3'd5
    } state_e;

    state_e              state_q;
    logic [BC_W-1:0]     bit_cnt_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic [WORD_W-1:0]   sreg_q;
    logic                fault_q;
    logic [WORD_W-1:0]   mem_q [POOL_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [LVL_W-1:0]    level_d;

    logic                active_s;
    logic                flush_s;
    logic                push_s;
    logic                pop_s;
    logic [WORD_W-1:0]   new_word_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign active_s   = (state_q == S_CALIB) || (state_q == S_WARMUP) ||
                        (state_q == S_COLLECT) || (state_q == S_STALL);
    assign flush_s    = (state_q == S_IDLE) || (state_q == S_FAULT);
    assign new_word_s = {sreg_q[WORD_W-2:0], adc_in};
    // A word completes only when no higher-priority exit (fault, disable) wins this cycle.
    assign push_s     = (state_q == S_COLLECT) && en && !oht_perm_fail &&
                        (bit_cnt_q == WORD_LAST) && (level_q != LVL_FULL);
    assign pop_s      = (level_q != '0) && word_ready;

    // Next pool occupancy; the FSM uses it so stall/resume decisions see this cycle's pop.
    always_comb begin
        level_d = level_q;
        if (flush_s) begin
            level_d = '0;
        end else if (push_s && !pop_s) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_s && !push_s) begin
            level_d = level_q - LVL_W'(1);
        end else begin
            level_d = level_q;
        end
    end

    // Pool pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            level_q <= level_d;
            if (flush_s) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (pop_s) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
            end
        end
    end

    // Pool storage; contents are only observable while the level is non-zero.
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            mem_q[wr_ptr_q] <= new_word_s;
        end
    end

    // Sequencer FSM with its counters, shift register and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            sreg_q    <= '0;
            fault_q   <= 1'b0;
        end else if (active_s && oht_perm_fail) begin
            state_q   <= S_FAULT;
            fault_q   <= 1'b1;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
        end else if (active_s && !en) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    to_cnt_q  <= '0;
                    bit_cnt_q <= '0;
                    sreg_q    <= '0;
                    if (en) begin
                        state_q <= S_CALIB;
                    end
                end
                S_CALIB: begin
                    if (oht_valid) begin
                        state_q   <= S_WARMUP;
                        bit_cnt_q <= '0;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q <= S_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_WARMUP: begin
                    if (bit_cnt_q == WARM_LAST) begin
                        state_q   <= S_COLLECT;
                        bit_cnt_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    end
                end
                S_COLLECT: begin
                    sreg_q <= new_word_s;
                    if (bit_cnt_q == WORD_LAST) begin
                        bit_cnt_q <= '0;
                        if (level_d == LVL_FULL) begin
                            state_q <= S_STALL;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    end
                end
                S_STALL: begin
                    if (level_d != LVL_FULL) begin
                        state_q   <= S_COLLECT;
                        bit_cnt_q <= '0;
                    end
                end
                S_FAULT: begin
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= S_FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    assign oht_rst    = (state_q == S_IDLE);
    assign oht_full   = (state_q == S_IDLE) || (state_q == S_STALL) || (state_q == S_FAULT);
    assign word_valid = (level_q != '0);
    assign word_out   = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign pool_level = level_q;
    assign state      = state_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_entropy_pool_ctrl.sv
// Randomized bench for entropy_pool_ctrl, checked every cycle against a queue-based
// reference model of the sequencing rules.
module tb_entropy_pool_ctrl;

    localparam int WORD_W      = 64;
    localparam int POOL_DEPTH  = 4;
    localparam int CAL_TIMEOUT = 4096;
    localparam int WARMUP_BITS = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              adc_in = 1'b0;
    logic              oht_valid = 1'b0;
    logic              oht_perm_fail = 1'b0;
    logic              word_ready = 1'b0;
    logic              oht_rst;
    logic              oht_full;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic [2:0]        pool_level;
    logic [2:0]        state;
    logic              fault;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state number, pool as a word queue, partial word as a bit queue.
    int                m_state = 0;
    logic [WORD_W-1:0] m_pool [$];
    bit                m_bits [$];
    int                m_tcnt = 0;
    int                m_wcnt = 0;
    bit                m_fault = 1'b0;

    entropy_pool_ctrl #(
        .WORD_W(WORD_W), .POOL_DEPTH(POOL_DEPTH),
        .CAL_TIMEOUT(CAL_TIMEOUT), .WARMUP_BITS(WARMUP_BITS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .adc_in(adc_in), .oht_valid(oht_valid),
        .oht_perm_fail(oht_perm_fail), .oht_rst(oht_rst), .oht_full(oht_full),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .pool_level(pool_level), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 30) begin
                $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
            end
        end
    endtask

    task automatic check_outputs();
        logic [63:0] exp_word;
        exp_word = (m_pool.size() != 0) ? m_pool[0] : 64'd0;
        check("state",      64'(state),      64'(m_state));
        check("pool_level", 64'(pool_level), 64'(m_pool.size()));
        check("word_valid", 64'(word_valid), 64'(m_pool.size() != 0));
        check("word_out",   word_out,        exp_word);
        check("fault",      64'(fault),      64'(m_fault));
        check("oht_full",   64'(oht_full),   64'(m_state == 0 || m_state == 4 || m_state == 5));
        check("oht_rst",    64'(oht_rst),    64'(m_state == 0));
    endtask

    task automatic model_update();
        bit          act;
        logic [63:0] w;
        act = (m_state >= 1 && m_state <= 4);
        if (rst) begin
            m_state = 0; m_pool.delete(); m_bits.delete();
            m_tcnt = 0; m_wcnt = 0; m_fault = 1'b0;
            return;
        end
        if (m_pool.size() != 0 && word_ready) void'(m_pool.pop_front());
        if (m_state == 0 || m_state == 5) m_pool.delete();
        if (act && oht_perm_fail) begin
            m_state = 5; m_fault = 1'b1; m_bits.delete();
        end else if (act && !en) begin
            m_state = 0; m_bits.delete();
        end else begin
            case (m_state)
                0: begin m_tcnt = 0; if (en) m_state = 1; end
                1: begin
                    if (oht_valid) begin m_state = 2; m_wcnt = 0; end
                    else if (m_tcnt == CAL_TIMEOUT - 1) begin m_state = 5; m_fault = 1'b1; end
                    else m_tcnt++;
                end
                2: begin
                    m_wcnt++;
                    if (m_wcnt == WARMUP_BITS) begin m_state = 3; m_bits.delete(); end
                end
                3: begin
                    m_bits.push_back(adc_in);
                    if (m_bits.size() == WORD_W) begin
                        w = 64'd0;
                        foreach (m_bits[i]) w[WORD_W-1-i] = m_bits[i];
                        m_pool.push_back(w);
                        m_bits.delete();
                        if (m_pool.size() == POOL_DEPTH) m_state = 4;
                    end
                end
                4: if (m_pool.size() < POOL_DEPTH) m_state = 3;
                default: ;
            endcase
        end
    endtask

    // One clock: check outputs, apply new inputs, advance the model, wait a full cycle.
    task automatic step(input bit r, input bit e, input bit a, input bit v,
                        input bit pf, input bit rd);
        check_outputs();
        rst = r; en = e; adc_in = a; oht_valid = v; oht_perm_fail = pf; word_ready = rd;
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    initial begin
        bit hit;
        @(posedge clk);
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);

        // Alternating bits, calibration done after 10 cycles, consumer always ready.
        for (int c = 0; c < 420; c++) step(0, 1, (c % 2) == 0, c >= 10, 0, 1);

        // Consumer stalls: pool fills, then a single pop resumes collection.
        for (int c = 0; c < 300; c++) step(0, 1, rb(), 1, 0, 0);
        check("stall_reached", 64'(state), 64'd4);
        step(0, 1, rb(), 1, 0, 1);
        for (int c = 0; c < 6; c++) step(0, 1, rb(), 1, 0, 0);

        // Random consumer: exercises simultaneous push and pop near full.
        for (int c = 0; c < 700; c++) step(0, 1, rb(), 1, 0, ($urandom_range(0, 3) != 0));

        // Disable mid-word, then re-enable and rerun calibration and warm-up.
        for (int c = 0; c < 30; c++) step(0, 1, rb(), 1, 0, 1);
        for (int c = 0; c < 3; c++) step(0, 0, rb(), 1, 0, 1);
        for (int c = 0; c < 400; c++) step(0, 1, rb(), c >= 5, 0, 1);

        // Permanent OHT failure while collecting with two words pooled.
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (m_state == 3 && m_pool.size() == 2) hit = 1'b1;
            else step(0, 1, rb(), 1, 0, 0);
        end
        check("lvl2_reached", 64'(hit), 64'd1);
        step(0, 1, rb(), 1, 1, 0);
        for (int c = 0; c < 5; c++) step(0, rb(), rb(), 1, 0, rb());
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Calibration never completes: timeout fault, en toggling ignored, reset clears.
        for (int c = 0; c < CAL_TIMEOUT + 4; c++) step(0, 1, rb(), 0, 0, 1);
        check("cal_timeout_fault", 64'(fault), 64'd1);
        for (int c = 0; c < 10; c++) step(0, c[0], rb(), rb(), 0, 1);
        step(1, 0, 0, 0, 0, 0);

        // Fully random traffic with rare failures, disables and resets.
        for (int c = 0; c < 2500; c++) begin
            step($urandom_range(0, 999) == 0, $urandom_range(0, 31) != 0, rb(),
                 $urandom_range(0, 7) != 0, $urandom_range(0, 799) == 0, rb());
        end
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
